// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule.
// Starts from the round-10 key and produces the round keys 10 down to 0,
// one per valid/ready handshake. Only the current round key is stored; the
// previous key is recomputed from it each step with one S-box layer.
// Parameter EMIT_ROUND0 (default 1) selects whether round 0 is emitted.
// Optional macro AES_INV_KEY_ZEROIZE_EN clears the key register when the
// sequence finishes, so key_out reads 0 from the done-pulse cycle onward.
module aes_inv_key_sched #(
   parameter int EMIT_ROUND0 = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] last_key,
   output logic         busy,
   output logic         key_valid,
   input  logic         key_ready,
   output logic [127:0] key_out,
   output logic [3:0]   key_round,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EMIT = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [3:0] LAST_ROUND = (EMIT_ROUND0 != 0) ? 4'd0 : 4'd1;

   // Forward AES S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] idx;
      idx = {~x, 3'b000};
      return SBOX_TABLE[idx +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Undo one forward expansion step: key of round r-1 from key of round r.
   function automatic logic [127:0] prev_round_key(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] a, b, c, d, p0, p1, p2, p3;
      {a, b, c, d} = k;
      p3 = d ^ c;
      p2 = c ^ b;
      p1 = b ^ a;
      p0 = a ^ rot_word(sub_word(p3)) ^ {rcon(r), 24'h000000};
      return {p0, p1, p2, p3};
   endfunction

   state_t        state_r, state_nx;
   logic [127:0]  key_r, key_nx;
   logic [3:0]    round_r, round_nx;
   logic          busy_r, busy_nx;
   logic          valid_r, valid_nx;
   logic          done_r, done_nx;
   logic          handshake_s;

   assign handshake_s = valid_r & key_ready;

   // Next-state, next-key and registered-output decode.
   always_comb begin
      state_nx = state_r;
      key_nx   = key_r;
      round_nx = round_r;
      busy_nx  = 1'b0;
      valid_nx = 1'b0;
      done_nx  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx = EMIT;
               key_nx   = last_key;
               round_nx = 4'd10;
               busy_nx  = 1'b1;
               valid_nx = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         EMIT: begin
            busy_nx  = 1'b1;
            valid_nx = 1'b1;
            if (handshake_s) begin
               if (round_r <= LAST_ROUND) begin
                  state_nx = DONE;
                  busy_nx  = 1'b0;
                  valid_nx = 1'b0;
                  done_nx  = 1'b1;
`ifdef AES_INV_KEY_ZEROIZE_EN
                  key_nx   = 128'h0;
`else
                  key_nx   = key_r;
`endif
               end else begin
                  key_nx   = prev_round_key(key_r, round_r);
                  round_nx = round_r - 4'd1;
               end
            end else begin
               state_nx = EMIT;
            end
         end
         DONE: begin
            state_nx = IDLE;
`ifdef AES_INV_KEY_ZEROIZE_EN
            key_nx   = 128'h0;
`else
            key_nx   = key_r;
`endif
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, key and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         key_r   <= 128'h0;
         round_r <= 4'd0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx;
         key_r   <= key_nx;
         round_r <= round_nx;
         busy_r  <= busy_nx;
         valid_r <= valid_nx;
         done_r  <= done_nx;
      end
   end

   assign busy      = busy_r;
   assign key_valid = valid_r;
   assign key_out   = key_r;
   assign key_round = round_r;
   assign done      = done_r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed self-checking bench for aes_inv_key_sched.
// dut0 uses the default EMIT_ROUND0=1, dut1 uses EMIT_ROUND0=0.
module tb_aes_inv_key_sched;

   logic          clk = 1'b0;
   logic          rst, start, key_ready;
   logic [127:0]  last_key;

   logic          busy0, key_valid0, done0;
   logic [127:0]  key_out0;
   logic [3:0]    key_round0;
   logic          busy1, key_valid1, done1;
   logic [127:0]  key_out1;
   logic [3:0]    key_round1;

   int vectors = 0;
   int miscompares = 0;

   logic [127:0] exp_tab [0:10];

   localparam logic [127:0] A1_LAST   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] C1_LAST   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1_ROUND0 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] JUNK      = 128'hdeadbeef0123456789abcdeffedcba98;

   aes_inv_key_sched dut0 (
      .clk(clk), .rst(rst), .start(start), .last_key(last_key),
      .busy(busy0), .key_valid(key_valid0), .key_ready(key_ready),
      .key_out(key_out0), .key_round(key_round0), .done(done0)
   );

   aes_inv_key_sched #(.EMIT_ROUND0(0)) dut1 (
      .clk(clk), .rst(rst), .start(start), .last_key(last_key),
      .busy(busy1), .key_valid(key_valid1), .key_ready(key_ready),
      .key_out(key_out1), .key_round(key_round1), .done(done1)
   );

   always #5 clk = ~clk;

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   function automatic logic [127:0] held_key(input logic [127:0] k);
`ifdef AES_INV_KEY_ZEROIZE_EN
      return 128'h0;
`else
      return k;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] lk);
      start    = 1'b1;
      last_key = lk;
      step();
      start    = 1'b0;
      last_key = JUNK;
   endtask

   // Called one step after start acceptance; returns in the done cycle.
   task automatic run_seq(input string tag, input int pct, input int last_rnd, input bit sel);
      int r, beats;
      bit fin, want_done;
      logic [127:0] ko;
      logic [3:0] kr;
      logic v, b, d;
      r = 10; beats = 0; fin = 1'b0; want_done = 1'b0;
      for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
         if (sel) begin
            ko = key_out1; kr = key_round1; v = key_valid1; b = busy1; d = done1;
         end else begin
            ko = key_out0; kr = key_round0; v = key_valid0; b = busy0; d = done0;
         end
         if (want_done) begin
            chk1({tag, " done"}, d, 1'b1);
            chk1({tag, " busy_in_done"}, b, 1'b0);
            chk1({tag, " valid_in_done"}, v, 1'b0);
            chk4({tag, " beats"}, 4'(beats), 4'(11 - last_rnd));
            key_ready = 1'b0;
            start     = 1'b0;
            fin       = 1'b1;
         end else begin
            chk1({tag, " valid"}, v, 1'b1);
            chk1({tag, " busy"}, b, 1'b1);
            chk1({tag, " no_early_done"}, d, 1'b0);
            chk128({tag, " key"}, ko, exp_tab[r]);
            chk4({tag, " round"}, kr, 4'(r));
            start     = (cyc == 3);
            last_key  = JUNK;
            key_ready = ($urandom_range(0, 99) < pct);
            if (v && key_ready) begin
               beats++;
               if (r == last_rnd) want_done = 1'b1;
               else r--;
            end
            step();
         end
      end
      chk1({tag, " finished_in_budget"}, fin, 1'b1);
   endtask

   initial begin
      logic [127:0] got;
      bit saw_done;

      exp_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      exp_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

      rst = 1'b1; start = 1'b0; key_ready = 1'b0; last_key = 128'h0;
      step();
      step();
      chk1("reset busy", busy0, 1'b0);
      chk1("reset valid", key_valid0, 1'b0);
      chk1("reset done", done0, 1'b0);
      chk128("reset key", key_out0, 128'h0);
      chk4("reset round", key_round0, 4'd0);

      // key_ready without a valid key does nothing
      rst = 1'b0;
      key_ready = 1'b1;
      step();
      step();
      chk1("idle ready valid", key_valid0, 1'b0);
      chk1("idle ready busy", busy0, 1'b0);
      key_ready = 1'b0;

      // A.1 vector at full throughput, then start during done is ignored
      do_start(A1_LAST);
      run_seq("a1", 100, 0, 1'b0);
      chk128("a1 held key", key_out0, held_key(exp_tab[0]));
      chk4("a1 held round", key_round0, 4'd0);
      start = 1'b1; last_key = C1_LAST;
      step();
      start = 1'b0;
      chk1("start_in_done busy", busy0, 1'b0);
      chk1("start_in_done valid", key_valid0, 1'b0);

      // Backpressure at 30 percent ready with an ignored mid-sequence start
      do_start(A1_LAST);
      run_seq("bp", 30, 0, 1'b0);
      step();

      // Second vector: C.1 round-10 key back to its cipher key
      do_start(C1_LAST);
      key_ready = 1'b1;
      chk128("c1 first key", key_out0, C1_LAST);
      got = 128'h0;
      for (int i = 0; i < 30 && !done0; i++) begin
         if (key_valid0 && key_round0 == 4'd0) got = key_out0;
         step();
      end
      chk1("c1 done", done0, 1'b1);
      chk128("c1 round0", got, C1_ROUND0);
      key_ready = 1'b0;
      step();

      // Reset in the middle of a sequence
      do_start(A1_LAST);
      key_ready = 1'b1;
      for (int i = 0; i < 30 && key_round0 != 4'd5; i++) step();
      chk4("mid round", key_round0, 4'd5);
      chk128("mid key", key_out0, exp_tab[5]);
      rst = 1'b1;
      #1;
      chk1("abort valid", key_valid0, 1'b0);
      chk1("abort busy", busy0, 1'b0);
      chk128("abort key", key_out0, 128'h0);
      chk4("abort round", key_round0, 4'd0);
      step();
      rst = 1'b0;
      saw_done = done0;
      for (int i = 0; i < 3; i++) begin
         step();
         saw_done = saw_done | done0;
      end
      chk1("abort no done", saw_done, 1'b0);
      key_ready = 1'b0;
      do_start(A1_LAST);
      run_seq("rerun", 100, 0, 1'b0);
      step();

      // EMIT_ROUND0=0 instance ends at round 1
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      do_start(A1_LAST);
      run_seq("er0", 100, 1, 1'b1);
      chk128("er0 held key", key_out1, held_key(exp_tab[1]));
      chk4("er0 held round", key_round1, 4'd1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
